lc3_io_ctrl: RTL and testbench

LC3_IO_CTRL -- requirements
Module: lc3_io_ctrl

---
 rtl/lc3_io_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lc3_io_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_io_ctrl.sv
// LC-3 memory-mapped keyboard/display controller: KBSR/KBDR/DSR/DDR.
// Define LC3_IO_INT_EN to build the interrupt enables and INT_REQ.
module lc3_io_ctrl #(
    parameter int          DATA_W    = 8,
    parameter int          KBD_DEPTH = 4,
    parameter logic [15:0] BASE      = 16'hFE00
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [15:0]       MAR_OUT,
    input  logic              MEM_RD,
    input  logic              MEM_WE,
    input  logic [15:0]       MDR_OUT,
    output logic              IO_SEL,
    output logic [15:0]       IO_DATA,
    input  logic              KBD_VALID,
    input  logic [DATA_W-1:0] KBD_DATA,
    output logic              KBD_READY,
    output logic              DSP_VALID,
    output logic [DATA_W-1:0] DSP_DATA,
    input  logic              DSP_READY,
    output logic              INT_REQ
);

    localparam int PW = $clog2(KBD_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0] A_KBSR = BASE;
    localparam logic [15:0] A_KBDR = BASE + 16'd2;
    localparam logic [15:0] A_DSR  = BASE + 16'd4;
    localparam logic [15:0] A_DDR  = BASE + 16'd6;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } dsp_state_e;

    logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
    logic rd_kbdr, wr_ddr;

    assign hit_kbsr = (MAR_OUT == A_KBSR);
    assign hit_kbdr = (MAR_OUT == A_KBDR);
    assign hit_dsr  = (MAR_OUT == A_DSR);
    assign hit_ddr  = (MAR_OUT == A_DDR);

    assign IO_SEL  = (hit_kbsr | hit_kbdr | hit_dsr | hit_ddr)
                   & (MEM_RD | MEM_WE);
    assign rd_kbdr = MEM_RD & hit_kbdr;
    assign wr_ddr  = MEM_WE & hit_ddr;

    logic [DATA_W-1:0] fifo_q [KBD_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              not_empty, full, push, pop;

    assign not_empty = (cnt_q != '0);
    assign full      = (cnt_q == CW'(KBD_DEPTH));
    assign KBD_READY = ~full;
    assign push      = KBD_VALID & ~full;
    // A read of an empty FIFO must not move the read pointer.
    assign pop       = rd_kbdr & not_empty;

    always_comb begin
        cnt_d = cnt_q;
        if (push & ~pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop & ~push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < KBD_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                fifo_q[wptr_q] <= KBD_DATA;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    dsp_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              dsp_idle;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_ddr) begin
                    state_d = S_BUSY;
                    hold_d  = MDR_OUT[DATA_W-1:0];
                end
            end
            S_BUSY: begin
                if (DSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign dsp_idle  = (state_q == S_IDLE);
    assign DSP_VALID = (state_q == S_BUSY);
    assign DSP_DATA  = hold_q;

    logic ie_k, ie_d;

`ifdef LC3_IO_INT_EN
    logic ie_k_q, ie_d_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ie_k_q <= 1'b0;
            ie_d_q <= 1'b0;
        end else begin
            if (MEM_WE & hit_kbsr) ie_k_q <= MDR_OUT[14];
            if (MEM_WE & hit_dsr)  ie_d_q <= MDR_OUT[14];
        end
    end

    assign ie_k    = ie_k_q;
    assign ie_d    = ie_d_q;
    assign INT_REQ = (ie_k & not_empty) | (ie_d & dsp_idle);
`else
    assign ie_k    = 1'b0;
    assign ie_d    = 1'b0;
    assign INT_REQ = 1'b0;
`endif

    logic [15:0] rdata;

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_kbsr: rdata = {not_empty, ie_k, 14'b0};
            hit_kbdr: rdata = not_empty ? 16'(fifo_q[rptr_q]) : 16'h0;
            hit_dsr:  rdata = {dsp_idle, ie_d, 14'b0};
            default:  rdata = '0;
        endcase
    end

    assign IO_DATA = IO_SEL ? rdata : 16'h0;

    logic unused_mdr;
    assign unused_mdr = ^MDR_OUT;

endmodule

// File: tb/tb_lc3_io_ctrl.sv
// Randomized bench for lc3_io_ctrl against a queue-based model.
// Build with LC3_IO_INT_EN to also exercise the interrupt path.
module tb_lc3_io_ctrl;

    localparam logic [15:0] BASE  = 16'hFE00;
    localparam int          DEPTH = 4;
    localparam logic [15:0] KBSR  = BASE;
    localparam logic [15:0] KBDR  = BASE + 16'd2;
    localparam logic [15:0] DSR   = BASE + 16'd4;
    localparam logic [15:0] DDR   = BASE + 16'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mar = '0;
    logic        mrd = 1'b0;
    logic        mwe = 1'b0;
    logic [15:0] mdr = '0;
    logic        io_sel;
    logic [15:0] io_data;
    logic        kv = 1'b0;
    logic [7:0]  kd = '0;
    logic        kr;
    logic        dv;
    logic [7:0]  dd;
    logic        dr = 1'b0;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] kq[$];
    bit         busy = 0;
    logic [7:0] dhold = '0;
    bit         iek = 0;
    bit         ied = 0;
`ifdef LC3_IO_INT_EN
    localparam bit INT_EN = 1;
`else
    localparam bit INT_EN = 0;
`endif

    lc3_io_ctrl #(.DATA_W(8), .KBD_DEPTH(DEPTH), .BASE(BASE)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .MAR_OUT(mar), .MEM_RD(mrd), .MEM_WE(mwe), .MDR_OUT(mdr),
        .IO_SEL(io_sel), .IO_DATA(io_data),
        .KBD_VALID(kv), .KBD_DATA(kd), .KBD_READY(kr),
        .DSP_VALID(dv), .DSP_DATA(dd), .DSP_READY(dr),
        .INT_REQ(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check combinational view, advance the model.
    task automatic step(input logic [15:0] a, input logic rd,
                        input logic we, input logic [15:0] wd,
                        input logic k_v, input logic [7:0] k_d,
                        input logic d_r);
        bit          hit, sel, do_pop, do_push;
        logic [15:0] rv;
        @(negedge clk);
        mar = a; mrd = rd; mwe = we; mdr = wd;
        kv = k_v; kd = k_d; dr = d_r;
        #1;
        hit = (a == KBSR) || (a == KBDR) || (a == DSR) || (a == DDR);
        sel = hit && (rd || we);
        rv  = 16'h0;
        if (a == KBSR) rv = {kq.size() != 0, iek, 14'b0};
        if (a == KBDR && kq.size() != 0) rv = {8'h00, kq[0]};
        if (a == DSR) rv = {!busy, ied, 14'b0};
        chk("io_sel", io_sel, sel);
        chk("io_data", io_data, sel ? rv : 16'h0);
        chk("kbd_ready", kr, kq.size() != DEPTH);
        chk("dsp_valid", dv, busy);
        if (busy) chk("dsp_data", dd, dhold);
        chk("int_req", irq, (iek && kq.size() != 0) || (ied && !busy));
        do_pop  = rd && a == KBDR && kq.size() != 0;
        do_push = k_v && kq.size() != DEPTH;
        if (do_pop) void'(kq.pop_front());
        if (do_push) kq.push_back(k_d);
        if (busy) begin
            if (d_r) busy = 0;
        end else if (we && a == DDR) begin
            busy  = 1;
            dhold = wd[7:0];
        end
        if (INT_EN && we && a == KBSR) iek = wd[14];
        if (INT_EN && we && a == DSR) ied = wd[14];
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0, 0, 0, 16'h0, 0, 8'h0, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a,
                          input logic [15:0] exp);
        @(negedge clk);
        mar = a; mrd = 1; mwe = 0; kv = 0; dr = 0;
        #1;
        chk(tag, io_data, exp);
        mrd = 0;
        // Step with read cleared: the model state stays in sync.
    endtask

    task automatic reset_now();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dsp_valid", dv, 1'b0);
        chk("rst_kbd_ready", kr, 1'b1);
        chk("rst_int_req", irq, 1'b0);
        mar = '0; mrd = 0; mwe = 0; kv = 0; dr = 0;
        kq.delete();
        busy = 0; dhold = '0; iek = 0; ied = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("por_kbd_ready", kr, 1'b1);
        chk("por_dsp_valid", dv, 1'b0);
        chk("por_int_req", irq, 1'b0);
        chk("por_io_data", io_data, 16'h0);
        rst_n = 1'b1;
        step(KBSR, 1, 0, 0, 0, 0, 0);
        step(DSR, 1, 0, 0, 0, 0, 0);
        step(DDR, 1, 0, 0, 0, 0, 0);
        step(KBDR, 1, 0, 0, 0, 0, 0);

        // Two characters in, two reads out, then status empty.
        step(0, 0, 0, 0, 1, 8'h41, 0);
        step(0, 0, 0, 0, 1, 8'h42, 0);
        rd_chk("kbsr_full", KBSR, 16'h8000);
        step(KBDR, 1, 0, 0, 0, 0, 0);
        step(KBDR, 1, 0, 0, 0, 0, 0);
        rd_chk("kbsr_empty", KBSR, 16'h0000);

        // Overfill: fifth push dropped.
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 1, 8'(i), 0);
        chk("full_ready", kr, 1'b0);
        for (int i = 0; i < 5; i++) step(KBDR, 1, 0, 0, 0, 0, 0);

        // Push and pop together at count 2.
        step(0, 0, 0, 0, 1, 8'h10, 0);
        step(0, 0, 0, 0, 1, 8'h11, 0);
        step(KBDR, 1, 0, 0, 1, 8'h12, 0);
        chk("pp_count", 32'(kq.size()), 32'd2);
        for (int i = 0; i < 3; i++) step(KBDR, 1, 0, 0, 0, 0, 0);
        // Push into empty while reading: read returns 0, push lands.
        step(KBDR, 1, 0, 0, 1, 8'h33, 0);
        step(KBDR, 1, 0, 0, 0, 0, 0);

        // Display transfer with stalled sink and ignored second write.
        step(DDR, 0, 1, 16'h0058, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(DSR, 1, 0, 0, 0, 0, 0);
        chk("dsp_hold", dd, 8'h58);
        step(DDR, 0, 1, 16'h0059, 0, 0, 0);
        chk("dsp_hold2", dd, 8'h58);
        step(0, 0, 0, 0, 0, 0, 1);
        step(DSR, 1, 0, 0, 0, 0, 0);
        rd_chk("dsr_idle", DSR, 16'h8000);

        // Interrupt enable path.
        step(KBSR, 0, 1, 16'h4000, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8'h55, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("irq_after_push", irq, INT_EN);
        step(KBDR, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("irq_after_read", irq, 1'b0);
        step(KBSR, 0, 1, 16'h0000, 0, 0, 0);
        step(DSR, 0, 1, 16'h4000, 0, 0, 0);
        idle(2);
        step(DSR, 0, 1, 16'h0000, 0, 0, 0);

        // Reset during a display transfer with queued keys.
        step(0, 0, 0, 0, 1, 8'h77, 0);
        step(DDR, 0, 1, 16'h0061, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        reset_now();
        step(DSR, 1, 0, 0, 0, 0, 0);
        step(KBSR, 1, 0, 0, 0, 0, 0);
        rd_chk("rst_dsr", DSR, 16'h8000);
        rd_chk("rst_kbsr", KBSR, 16'h0000);

        // Random traffic, including near-miss addresses.
        for (int i = 0; i < 400; i++) begin
            int          r, op;
            logic [15:0] a;
            r  = $urandom_range(0, 9);
            op = $urandom_range(0, 3);
            if (r < 4) a = BASE + 16'(2 * r);
            else if (r == 4) a = BASE + 16'd1;
            else if (r == 5) a = BASE + 16'd8;
            else a = 16'($urandom);
            step(a, op == 1 || op == 3, op == 2, 16'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 2) == 0);
            if (i == 200) reset_now();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
